// File: rtl/mux41_sel8.sv
// 8:1 registered multiplexer with enable, valid flag and registered select.
// Every output is a flop, so there is no combinational path from any input
// to any output. Latency is one clock from the sampling edge.
module mux41_sel8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       sel_q
);

    // Channels gathered into an array so the decode can be generated.
    logic [WIDTH-1:0] chan [8];
    logic [7:0]       sel_onehot;

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             valid_reg;
    logic [2:0]       sel_q_reg;

    assign chan[0] = a;
    assign chan[1] = b;
    assign chan[2] = c;
    assign chan[3] = d;
    assign chan[4] = e;
    assign chan[5] = f;
    assign chan[6] = g;
    assign chan[7] = h;

    // Full one-hot decode of sel; every code maps to exactly one channel.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_decode
            assign sel_onehot[gi] = (sel == 3'(gi));
        end
    endgenerate

    // AND-OR select of the chosen channel; disabled cycles load zero.
    always_comb begin
        out_next = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel_onehot[i]) begin
                out_next = out_next | chan[i];
            end
        end
        if (!en) begin
            out_next = '0;
        end
    end

    // Output registers; reset wins over enable and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
            sel_q_reg <= 3'd0;
        end else begin
            out_reg   <= out_next;
            valid_reg <= en;
            sel_q_reg <= sel;
        end
    end

    assign out       = out_reg;
    assign out_valid = valid_reg;
    assign sel_q     = sel_q_reg;

endmodule

// File: tb/tb_mux41_sel8.sv
// Self-checking bench for mux41_sel8: directed vectors with literal
// expectations plus a per-cycle comparison against a reference model.
module tb_mux41_sel8;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]       sel;
    logic             en;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [2:0]       sel_q;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the outputs must hold after the last edge.
    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;
    logic [2:0]       exp_sel_q;
    logic             model_ready = 1'b0;

    mux41_sel8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .sel       (sel),
        .en        (en),
        .out       (out),
        .out_valid (out_valid),
        .sel_q     (sel_q)
    );

    always #5 clk = ~clk;

    // Model: look the selected channel up by number in a data table.
    always @(posedge clk) begin
        logic [WIDTH-1:0] data_tbl [8];
        data_tbl = '{a, b, c, d, e, f, g, h};
        if (rst) begin
            exp_out     <= '0;
            exp_valid   <= 1'b0;
            exp_sel_q   <= 3'd0;
            model_ready <= 1'b1;
        end else begin
            exp_out   <= en ? data_tbl[sel] : '0;
            exp_valid <= en;
            exp_sel_q <= sel;
        end
    end

    // Per-cycle compare on the falling edge, once a reset has been seen.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                checks++;
                if (out !== exp_out || out_valid !== exp_valid || sel_q !== exp_sel_q) begin
                    failures++;
                    $display("FAIL model_cmp t=%0t: got out=%0h valid=%0b sel_q=%0d, expected out=%0h valid=%0b sel_q=%0d",
                             $time, out, out_valid, sel_q, exp_out, exp_valid, exp_sel_q);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic set_data(input logic [WIDTH-1:0] v0, v1, v2, v3, v4, v5, v6, v7);
        a = v0; b = v1; c = v2; d = v3; e = v4; f = v5; g = v6; h = v7;
    endtask

    initial begin
        logic [WIDTH-1:0] sweep_exp [8];
        logic [WIDTH-1:0] alt_exp [2];
        sweep_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        alt_exp   = '{8'd1, 8'd2};

        // Reset with enable high and a non-zero select: reset must win.
        rst = 1'b1; en = 1'b1; sel = 3'd5;
        set_data(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        step(); step();
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_sel_q", 32'(sel_q), 32'h0);
        rst = 1'b0;

        // Select sweep 0..7 with data 1..8.
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            chk($sformatf("sweep_out_sel%0d", s), 32'(out), 32'(sweep_exp[s]));
            chk($sformatf("sweep_selq_%0d", s), 32'(sel_q), 32'(s));
            chk($sformatf("sweep_valid_%0d", s), 32'(out_valid), 32'h1);
        end

        // Enable toggling 1,0,1 with sel=3.
        sel = 3'd3;
        en = 1'b1; step();
        chk("en1_out", 32'(out), 32'h4);
        chk("en1_valid", 32'(out_valid), 32'h1);
        en = 1'b0; step();
        chk("en0_out", 32'(out), 32'h0);
        chk("en0_valid", 32'(out_valid), 32'h0);
        chk("en0_sel_q", 32'(sel_q), 32'h3);
        en = 1'b1; step();
        chk("en1b_out", 32'(out), 32'h4);
        chk("en1b_valid", 32'(out_valid), 32'h1);

        // Mid-stream reset with sel=7, then recovery.
        sel = 3'd7; rst = 1'b1; step();
        chk("rst_mid_out", 32'(out), 32'h0);
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_sel_q", 32'(sel_q), 32'h0);
        rst = 1'b0; step();
        chk("rst_rec_out", 32'(out), 32'h8);
        chk("rst_rec_valid", 32'(out_valid), 32'h1);
        chk("rst_rec_sel_q", 32'(sel_q), 32'h7);

        // Data change between edges must not reach out until the next edge.
        sel = 3'd0; a = 8'd1; step();
        chk("hold_before", 32'(out), 32'h1);
        #2 a = 8'hFF;
        #1 chk("hold_between", 32'(out), 32'h1);
        step();
        chk("hold_after", 32'(out), 32'hFF);

        // Alternating select with a=1, b=2; sel and data change together too.
        a = 8'd1; b = 8'd2;
        for (int i = 0; i < 6; i++) begin
            sel = 3'(i % 2);
            step();
            chk($sformatf("alt_out_%0d", i), 32'(out), 32'(alt_exp[i % 2]));
        end
        sel = 3'd6; g = 8'hA5; step();
        chk("sel_data_same_edge", 32'(out), 32'hA5);

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 1000; i++) begin
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            sel = 3'($urandom_range(0, 7));
            en  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        step();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
